// File: rtl/vga_scanner.sv
// Raster scanner for the Game-of-Life display: VGA timing, pan/zoom cell mapping,
// synchronous cell-memory fetch and colour generation, with every output aligned 4 cycles late.
module vga_scanner #(
  parameter int unsigned WIDTH      = 12,
  parameter int unsigned HSIZE      = 800,
  parameter int unsigned HFP        = 856,
  parameter int unsigned HSP        = 976,
  parameter int unsigned HMAX       = 1040,
  parameter int unsigned VSIZE      = 600,
  parameter int unsigned VFP        = 637,
  parameter int unsigned VSP        = 643,
  parameter int unsigned VMAX       = 666,
  parameter bit          HSPP       = 1'b1,
  parameter bit          VSPP       = 1'b1,
  parameter int unsigned P_PARAM_N  = 200,
  parameter int unsigned P_PARAM_M  = 150,
  parameter int unsigned BLOCK_LEN  = 32,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned MAX_SCROLL = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          shift_x,
  input  logic [15:0]          shift_y,
  input  logic [3:0]           scroll,
  input  logic [1:0]           color_mode,
  input  logic                 setting_status,
  input  logic [2*WIDTH-1:0]   setting_pos,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [BLOCK_LEN-1:0] rd_data,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 data_enable,
  output logic [7:0]           video_red,
  output logic [7:0]           video_green,
  output logic [7:0]           video_blue,
  output logic                 frame_start
);
  localparam int unsigned CW = (WIDTH > 16 ? WIDTH : 16) + 1;
  localparam int unsigned IW = 2 * WIDTH;
  localparam int unsigned BW = $clog2(BLOCK_LEN);

  logic [WIDTH-1:0] h_q, v_q;
  logic [15:0]      sx_q, sy_q;
  logic [3:0]       sc_q;
  logic [1:0]       mode_q;
  logic             cur_en_q;
  logic [IW-1:0]    cur_pos_q;
  logic             h_last, v_last;

  assign h_last = (h_q == WIDTH'(HMAX - 1));
  assign v_last = (v_q == WIDTH'(VMAX - 1));

  // Shadows only load on the last pixel of a frame, so a frame never mixes settings.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q       <= '0;
      v_q       <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
      sc_q      <= '0;
      mode_q    <= '0;
      cur_en_q  <= 1'b0;
      cur_pos_q <= '0;
    end else begin
      h_q <= h_last ? '0 : h_q + 1'b1;
      if (h_last) v_q <= v_last ? '0 : v_q + 1'b1;
      if (h_last && v_last) begin
        if (32'(shift_x) < P_PARAM_N) sx_q <= shift_x;
        if (32'(shift_y) < P_PARAM_M) sy_q <= shift_y;
        sc_q      <= (32'(scroll) > MAX_SCROLL) ? 4'(MAX_SCROLL) : scroll;
        mode_q    <= color_mode;
        cur_en_q  <= setting_status;
        cur_pos_q <= setting_pos;
      end
    end
  end

  logic [WIDTH-1:0] hs, vs, cell_mask;
  logic [CW-1:0]    cx_sum, cy_sum, cx_d, cy_d;
  logic             oog_d, edge_d, de_d, hsync_d, vsync_d, fs_d;

  always_comb begin
    hs        = h_q >> sc_q;
    vs        = v_q >> sc_q;
    oog_d     = (CW'(hs) >= CW'(P_PARAM_N)) || (CW'(vs) >= CW'(P_PARAM_M));
    cx_sum    = CW'(hs) + CW'(sx_q);
    cy_sum    = CW'(vs) + CW'(sy_q);
    cx_d      = (cx_sum >= CW'(P_PARAM_N)) ? cx_sum - CW'(P_PARAM_N) : cx_sum;
    cy_d      = (cy_sum >= CW'(P_PARAM_M)) ? cy_sum - CW'(P_PARAM_M) : cy_sum;
    cell_mask = ~({WIDTH{1'b1}} << sc_q);
    edge_d    = (mode_q == 2'd2) && (sc_q >= 4'd2) &&
                (((h_q & cell_mask) == '0) || ((v_q & cell_mask) == '0));
    de_d      = (h_q < WIDTH'(HSIZE)) && (v_q < WIDTH'(VSIZE));
    hsync_d   = ((h_q >= WIDTH'(HFP)) && (h_q < WIDTH'(HSP))) ? HSPP : !HSPP;
    vsync_d   = ((v_q >= WIDTH'(VFP)) && (v_q < WIDTH'(VSP))) ? VSPP : !VSPP;
    fs_d      = (h_q == '0) && (v_q == '0);
  end

  logic [CW-1:0]    cx1_q, cy1_q;
  logic             oog1_q, edge1_q, oog2_q, edge2_q, oog3_q, edge3_q;
  logic [IW-1:0]    idx_d, idx2_q, idx3_q;
  logic [BW-1:0]    bit2_q, bit3_q;
  logic [3:0]       de_sr_q, hs_sr_q, vs_sr_q, fs_sr_q;
  logic [7:0]       red_d, green_d, blue_d;
  logic             live, cur_hit;

  assign idx_d = IW'(cy1_q) * IW'(P_PARAM_N) + IW'(cx1_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx1_q       <= '0;
      cy1_q       <= '0;
      oog1_q      <= 1'b0;
      edge1_q     <= 1'b0;
      idx2_q      <= '0;
      bit2_q      <= '0;
      oog2_q      <= 1'b0;
      edge2_q     <= 1'b0;
      rd_addr     <= '0;
      idx3_q      <= '0;
      bit3_q      <= '0;
      oog3_q      <= 1'b0;
      edge3_q     <= 1'b0;
      de_sr_q     <= '0;
      hs_sr_q     <= {4{!HSPP}};
      vs_sr_q     <= {4{!VSPP}};
      fs_sr_q     <= '0;
      video_red   <= '0;
      video_green <= '0;
      video_blue  <= '0;
    end else begin
      cx1_q   <= cx_d;
      cy1_q   <= cy_d;
      oog1_q  <= oog_d;
      edge1_q <= edge_d;
      idx2_q  <= idx_d;
      bit2_q  <= idx_d[BW-1:0];
      oog2_q  <= oog1_q;
      edge2_q <= edge1_q;
      if (de_sr_q[0] && !oog1_q) rd_addr <= ADDR_W'(idx_d >> BW);
      // Extra stage keeps idx/bit aligned with the RAM's one-cycle read latency.
      idx3_q      <= idx2_q;
      bit3_q      <= bit2_q;
      oog3_q      <= oog2_q;
      edge3_q     <= edge2_q;
      de_sr_q     <= {de_sr_q[2:0], de_d};
      hs_sr_q     <= {hs_sr_q[2:0], hsync_d};
      vs_sr_q     <= {vs_sr_q[2:0], vsync_d};
      fs_sr_q     <= {fs_sr_q[2:0], fs_d};
      video_red   <= red_d;
      video_green <= green_d;
      video_blue  <= blue_d;
    end
  end

  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    live    = rd_data[bit3_q];
    cur_hit = cur_en_q && (idx3_q == cur_pos_q);
    if (de_sr_q[2]) begin
      if (oog3_q) begin
        {red_d, green_d, blue_d} = 24'h202020;
      end else if (cur_hit) begin
        {red_d, green_d, blue_d} = live ? 24'hFF0000 : 24'h0000FF;
      end else if (live) begin
        if (mode_q == 2'd1) begin
          red_d   = {idx3_q[4:0], idx3_q[7:5]};
          green_d = {idx3_q[2:0], idx3_q[7:3]};
          blue_d  = 8'hFF;
        end else begin
          {red_d, green_d, blue_d} = 24'hFFFFFF;
        end
      end else if (edge3_q) begin
        {red_d, green_d, blue_d} = 24'h404040;
      end
    end
  end

  assign data_enable = de_sr_q[3];
  assign hsync       = hs_sr_q[3];
  assign vsync       = vs_sr_q[3];
  assign frame_start = fs_sr_q[3];

endmodule

// File: tb/tb_vga_scanner.sv
// Bench for vga_scanner on a shrunken raster: per-cycle comparison against a pixel-level
// model of the frame, plus literal spot checks on chosen pixels.
module tb_vga_scanner;
  localparam int unsigned WIDTH = 6;
  localparam int unsigned HSIZE = 24, HFP = 26, HSP = 29, HMAX = 32;
  localparam int unsigned VSIZE = 16, VFP = 17, VSP = 19, VMAX = 20;
  localparam bit          HSPP = 1'b1, VSPP = 1'b0;
  localparam int unsigned N = 16, M = 12, BL = 8, AW = 5, MAXS = 4;
  localparam int unsigned FRAME = HMAX * VMAX;
  localparam int unsigned WORDS = N * M / BL;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [15:0]        shift_x = '0, shift_y = '0;
  logic [3:0]         scroll = '0;
  logic [1:0]         color_mode = '0;
  logic               setting_status = 1'b0;
  logic [2*WIDTH-1:0] setting_pos = '0;
  logic [AW-1:0]      rd_addr;
  logic [BL-1:0]      rd_data = '0;
  logic               hsync, vsync, data_enable, frame_start;
  logic [7:0]         video_red, video_green, video_blue;
  logic [BL-1:0]      mem [WORDS];

  int checks = 0;
  int errors = 0;
  int e = 0;
  int nf;
  int fr_sx [64], fr_sy [64], fr_sc [64], fr_mode [64], fr_cen [64], fr_cpos [64];

  always #5 clk = ~clk;

  vga_scanner #(
    .WIDTH(WIDTH), .HSIZE(HSIZE), .HFP(HFP), .HSP(HSP), .HMAX(HMAX),
    .VSIZE(VSIZE), .VFP(VFP), .VSP(VSP), .VMAX(VMAX), .HSPP(HSPP), .VSPP(VSPP),
    .P_PARAM_N(N), .P_PARAM_M(M), .BLOCK_LEN(BL), .ADDR_W(AW), .MAX_SCROLL(MAXS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .shift_x(shift_x), .shift_y(shift_y), .scroll(scroll),
    .color_mode(color_mode), .setting_status(setting_status), .setting_pos(setting_pos),
    .rd_addr(rd_addr), .rd_data(rd_data), .hsync(hsync), .vsync(vsync),
    .data_enable(data_enable), .video_red(video_red), .video_green(video_green),
    .video_blue(video_blue), .frame_start(frame_start)
  );

  always @(posedge clk) rd_data <= (int'(rd_addr) < WORDS) ? mem[rd_addr] : '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Edge count since release; settings each frame sees are captured at the frame's last pixel.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e <= 0;
      fr_sx[0] = 0; fr_sy[0] = 0; fr_sc[0] = 0;
      fr_mode[0] = 0; fr_cen[0] = 0; fr_cpos[0] = 0;
    end else begin
      if ((e % FRAME == FRAME - 1) && (e / FRAME < 63)) begin
        nf = e / FRAME + 1;
        fr_sx[nf]   = (shift_x < N) ? int'(shift_x) : fr_sx[nf-1];
        fr_sy[nf]   = (shift_y < M) ? int'(shift_y) : fr_sy[nf-1];
        fr_sc[nf]   = (scroll > MAXS) ? MAXS : int'(scroll);
        fr_mode[nf] = int'(color_mode);
        fr_cen[nf]  = int'(setting_status);
        fr_cpos[nf] = int'(setting_pos);
      end
      e <= e + 1;
    end
  end

  function automatic logic [23:0] model_rgb(int h, int v, int f);
    int sc, gx, gy, cx, cy, idx;
    logic live;
    logic [7:0] b;
    sc = fr_sc[f];
    if (h >= HSIZE || v >= VSIZE) return 24'h0;
    gx = h >> sc;
    gy = v >> sc;
    if (gx >= N || gy >= M) return 24'h202020;
    cx = (gx + fr_sx[f]) % N;
    cy = (gy + fr_sy[f]) % M;
    idx = cy * N + cx;
    live = mem[idx / BL][idx % BL];
    if (fr_cen[f] != 0 && idx == fr_cpos[f]) return live ? 24'hFF0000 : 24'h0000FF;
    if (live) begin
      b = 8'(idx);
      if (fr_mode[f] == 1) return {b[4:0], b[7:5], b[2:0], b[7:3], 8'hFF};
      return 24'hFFFFFF;
    end
    if (fr_mode[f] == 2 && sc >= 2 && ((h % (1 << sc)) == 0 || (v % (1 << sc)) == 0))
      return 24'h404040;
    return 24'h0;
  endfunction

  int cp, ch, cv, cf, qp, qh, qv, qf, qidx;
  int de_cnt, hs_cnt, last_fs;
  logic [31:0] act_v, exp_v;

  always @(negedge clk) begin
    if (!rst_n) begin
      de_cnt = 0; hs_cnt = 0; last_fs = -1;
    end else if (e < 4) begin
      chk("reset_pipe", {4'h0, data_enable, hsync, vsync, frame_start,
                         video_red, video_green, video_blue},
          {4'h0, 1'b0, !HSPP, !VSPP, 1'b0, 24'h0});
    end else begin
      cp = e - 4; ch = cp % HMAX; cv = (cp / HMAX) % VMAX; cf = cp / FRAME;
      act_v = {4'h0, data_enable, hsync, vsync, frame_start, video_red, video_green, video_blue};
      exp_v = {4'h0, (ch < HSIZE && cv < VSIZE), ((ch >= HFP && ch < HSP) ? HSPP : !HSPP),
               ((cv >= VFP && cv < VSP) ? VSPP : !VSPP), (ch == 0 && cv == 0),
               model_rgb(ch, cv, cf)};
      chk($sformatf("pixel(%0d,%0d)", ch, cv), act_v, exp_v);
      de_cnt += int'(data_enable);
      hs_cnt += int'(hsync == HSPP);
      if (frame_start) begin
        if (last_fs >= 0) chk("fs_period", e - last_fs, FRAME);
        last_fs = e;
      end
      if (ch == HMAX - 1 && cv == VMAX - 1) begin
        chk("de_per_frame", de_cnt, HSIZE * VSIZE);
        chk("hsync_per_frame", hs_cnt, (HSP - HFP) * VMAX);
        de_cnt = 0; hs_cnt = 0;
      end
      qp = e - 2; qh = qp % HMAX; qv = (qp / HMAX) % VMAX; qf = qp / FRAME;
      if (qh < HSIZE && qv < VSIZE && (qh >> fr_sc[qf]) < N && (qv >> fr_sc[qf]) < M) begin
        qidx = ((qv >> fr_sc[qf]) + fr_sy[qf]) % M * N + ((qh >> fr_sc[qf]) + fr_sx[qf]) % N;
        chk("rd_addr", rd_addr, qidx / BL);
      end
    end
  end

  task automatic wait_ctr(input int hh, input int vv);
    bit found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge clk);
      if (e % FRAME == vv * HMAX + hh) found = 1;
    end
    if (!found) chk("wait_ctr_timeout", 0, 1);
  endtask

  task automatic wait_out(input int hh, input int vv);
    bit found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge clk);
      if (e >= 4 && (e - 4) % FRAME == vv * HMAX + hh) found = 1;
    end
    if (!found) chk("wait_out_timeout", 0, 1);
  endtask

  function automatic logic [31:0] rgb();
    return {8'h0, video_red, video_green, video_blue};
  endfunction

  task automatic release_and_check_fs();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fs_early", frame_start, 1'b0);
    end
    @(negedge clk);
    chk("fs_first", frame_start, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = '0;
    mem[0] = 8'h01;
    repeat (2) @(negedge clk);
    release_and_check_fs();
    // Only cell 0 live
    wait_out(0, 0);  chk("p00_white", rgb(), 32'hFFFFFF);
    wait_out(1, 0);  chk("p10_black", rgb(), 32'h000000);
    wait_out(20, 0); chk("oog_grey", rgb(), 32'h202020);

    // Pan with wrap
    wait_ctr(0, 17);
    for (int i = 0; i < WORDS; i++) mem[i] = 8'((i * 73 + 29) ^ (i << 2));
    mem[0] = 8'h00; mem[6] = 8'h01; mem[7] = 8'h00;
    shift_x = 16'd15; shift_y = 16'd3;
    wait_out(0, 0); chk("pan_p00", rgb(), 32'h000000);
    wait_out(1, 0); chk("pan_wrap", rgb(), 32'hFFFFFF);

    // Illegal pan values keep the previous shadow
    wait_ctr(0, 17);
    shift_x = 16'd250; shift_y = 16'd99;
    wait_out(1, 0); chk("pan_hold", rgb(), 32'hFFFFFF);

    // Zoom clamp with grid lines
    wait_ctr(0, 17);
    shift_x = 16'd0; shift_y = 16'd0; scroll = 4'd9; color_mode = 2'd2;
    wait_out(16, 1); chk("clamp_edge", rgb(), 32'h404040);

    // Grid mode, all dead, 4-pixel cells
    wait_ctr(0, 17);
    for (int i = 0; i < WORDS; i++) mem[i] = '0;
    scroll = 4'd2;
    wait_out(4, 1); chk("grid_col", rgb(), 32'h404040);
    wait_out(5, 4); chk("grid_row", rgb(), 32'h404040);
    wait_out(5, 5); chk("grid_inner", rgb(), 32'h000000);

    // Cursor, changed mid-frame
    wait_ctr(0, 17);
    color_mode = 2'd0; scroll = 4'd1; mem[12] = 8'h02;
    setting_status = 1'b1; setting_pos = 12'd97;
    wait_ctr(0, 4);
    setting_pos = 12'd98;
    wait_out(2, 12); chk("cur_live", rgb(), 32'hFF0000);
    wait_out(2, 12); chk("cur_moved", rgb(), 32'hFFFFFF);
    wait_out(4, 12); chk("cur_dead", rgb(), 32'h0000FF);

    // Hashed colour
    wait_ctr(0, 17);
    for (int i = 0; i < WORDS; i++) mem[i] = 8'((i * 73 + 29) ^ (i << 2));
    mem[11] = 8'h04;
    setting_status = 1'b0; scroll = 4'd0; color_mode = 2'd1;
    wait_out(10, 5); chk("hash_5a", rgb(), 32'hD24BFF);
    wait_out(11, 5); chk("hash_dead", rgb(), 32'h000000);

    // Mid-frame asynchronous reset
    wait_ctr(0, 8);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sync", {data_enable, hsync, vsync, frame_start}, 4'b0010);
    chk("rst_video", rgb(), 32'h0);
    chk("rst_addr", rd_addr, 0);
    @(negedge clk);
    @(negedge clk);
    release_and_check_fs();
    wait_out(10, 5); chk("post_rst_mono", rgb(), 32'hFFFFFF);
    wait_out(10, 5); chk("post_rst_hash", rgb(), 32'hD24BFF);
    wait_out(HMAX - 1, VMAX - 1);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_scanner.md
# vga_scanner

Parametrised raster scanner and pixel pipeline for the Game-of-Life display path. It generates VGA timing and maps each visible pixel to a grid cell under per-frame pan (wrapping, toroidal) and power-of-two zoom. It fetches the cell's live bit from packed cell memory through a synchronous read port and emits colour, sync and enable signals aligned to one another. Pan, zoom, cursor and colour mode are shadow-latched at frame boundaries so that a frame never tears.

## Interface
- WIDTH, 12: bits of the h/v counters.
- HSIZE/HFP/HSP/HMAX, 800/856/976/1040: horizontal visible / front-porch end / sync end / total.
- VSIZE/VFP/VSP/VMAX, 600/637/643/666: vertical equivalents.
- HSPP/VSPP, 1/1: sync polarity (1 = positive).
- P_PARAM_N, 200: grid columns. P_PARAM_M, 150: grid rows.
- BLOCK_LEN, 32: cells per memory word (power of two).
- ADDR_W, 10: rd_addr width, ≥ ceil(log2(N·M/BLOCK_LEN)).
- MAX_SCROLL, 4: maximum zoom shift.
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous, active-low reset.
- shift_x  in  16  pan column, legal < N.
- shift_y  in  16  pan row, legal < M.
- scroll  in  4  zoom: each cell is 2^scroll pixels square.
- color_mode  in  2  0 mono, 1 hashed, 2 grid, 3 treated as 0.
- setting_status  in  1  cursor enable.
- setting_pos  in  2·WIDTH  cursor linear cell index (y·N+x).
- rd_addr  out  ADDR_W  cell-memory word address.
- rd_data  in  BLOCK_LEN  word returned one cycle after rd_addr.
- hsync, vsync, data_enable  out  1 each.
- video_red/green/blue  out  8 each.
- frame_start  out  1  one-cycle pulse.

## Operation
- Counters h,v: h wraps at HMAX-1; v increments on h wrap and wraps at VMAX-1.
- Shadow registers (sx, sy, sc, mode, cur_en, cur_pos) load when h==HMAX-1 && v==VMAX-1.
  - sx loads only if shift_x < N; otherwise it keeps its old value. sy follows the same rule against M.
  - sc = min(scroll, MAX_SCROLL).
- Coordinate mapping:
  - If (h>>sc) ≥ N or (v>>sc) ≥ M, the pixel is out-of-grid.
  - Otherwise cx = (h>>sc)+sx, minus N if ≥ N (single conditional subtract). cy is computed the same way against M.
  - idx = cy·N+cx; rd_addr = idx / BLOCK_LEN; bit = idx % BLOCK_LEN; live = rd_data[bit].
- Colour, active region only, in priority order:
  1. Out-of-grid: 0x20/0x20/0x20.
  2. Cursor (cur_en && idx==cur_pos): live → FF/00/00; dead → 00/00/FF.
  3. Live cell, mode 0/2/3: FF/FF/FF. Live cell, mode 1: R={idx[4:0],idx[7:5]}, G={idx[2:0],idx[7:3]}, B=FF.
  4. Dead cell in mode 2 with sc ≥ 2, on the first pixel row or column of the cell ((h or v) low sc bits == 0): 40/40/40.
  5. Otherwise dead: 00/00/00.
- Outside the active region: video 0. rd_addr holds its last value (don't-care).
- hsync = HSPP when HFP ≤ h < HSP, else !HSPP. vsync uses VFP/VSP/VSPP likewise. data_enable = h<HSIZE && v<VSIZE.
- frame_start is raised for the pixel h=0, v=0.

## Timing
- Pipeline, with counters at cycle k:
  - S1 (end of k): out-of-grid flag, cx, cy.
  - S2 (end of k+1): rd_addr, bit, idx.
  - RAM (end of k+2): rd_data.
  - S3 (end of k+3): video.
- Total latency is 4 cycles. hsync, vsync, data_enable and frame_start are derived at k and delayed 4 registers, so every output describes the same pixel.
- Shadow values are used from the first pixel of the frame. Shadow registers sit at the counter stage, so a change never splits a frame.
- Reset (asynchronous, any time): h=v=0, shadows 0, rd_addr 0, video 0, data_enable 0, frame_start 0, hsync=!HSPP, vsync=!VSPP, delay lines cleared.
- After release, the first frame_start appears 4 cycles after the first rising edge.
- Mid-frame reset restarts at pixel (0,0) with no partial-frame artefacts after release.
- Simultaneous input change and frame boundary: values sampled on that edge apply to the next frame.

## Test plan
- Reset then run, default params: frame_start every 1040·666 cycles; hsync high for 120 cycles per line; data_enable high for 800 cycles per line on 600 lines; all aligned.
- Memory model returns word with only bit 0 set, sc=0, sx=sy=0: pixel (0,0) white 4 cycles after counters reach (0,0); pixel (1,0) black; rd_addr=0 for h<32.
- sx=199 (N=200), sc=0: pixel h=1 maps to cx=0. shift_x=250: sx keeps the previous value.
- scroll=9: clamped to 4. Pixel h=3199 is not reached; h≥3200 never occurs, so pixels with h>>4 ≥ 200 stay inside the grid (50 columns visible). With N=40, pixels h ≥ 640 are grey 0x20.
- Cursor at idx 201, setting_status=1, sc=1: pixels (2..3, 2..3) red if live, blue if dead. A change mid-frame takes effect only in the next frame.
- Mode 1, live idx 0x5A: R=0xD2, G=0x4B, B=0xFF. Mode 2, sc=2, dead: cell-edge pixels 0x40.
